// File: rtl/addsub_pipe_if.sv
// addsub_pipe_if: ready/valid bundle for addsub_pipe.
//   valid_i/ready_o/a_i/b_i/op_i : upstream request side
//   valid_o/ready_i/c_o          : downstream result side
// master = producer/consumer environment, slave = the pipe itself.
interface addsub_pipe_if #(
    parameter int width_p = 32
);
    logic               valid_i;
    logic               ready_o;
    logic [width_p-1:0] a_i;
    logic [width_p-1:0] b_i;
    logic [1:0]         op_i;
    logic               valid_o;
    logic               ready_i;
    logic [width_p:0]   c_o;

    modport master (
        output valid_i, a_i, b_i, op_i, ready_i,
        input  ready_o, valid_o, c_o
    );

    modport slave (
        input  valid_i, a_i, b_i, op_i, ready_i,
        output ready_o, valid_o, c_o
    );
endinterface

// File: rtl/addsub_pipe.sv
// addsub_pipe: elastic add/sub/accumulate pipeline.
//   clk_i    : rising-edge clock
//   reset_ni : asynchronous active-low reset
//   io       : slave side of addsub_pipe_if
//     op_i 0 = ADD, 1 = SUB, 2 = ACC (acc += a), 3 = LOAD (acc = a)
//   Result is width_p+1 bits, presented stages_p register stages after accept.
module addsub_pipe #(
    parameter int width_p  = 32,
    parameter int stages_p = 2
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    addsub_pipe_if.slave io
);
    localparam int DW = width_p + 1;
    typedef logic [DW-1:0] data_t;

    logic  [stages_p-1:0] valid_q, valid_d;
    data_t [stages_p-1:0] data_q, data_d;
    data_t                acc_q, acc_d;

    logic  [stages_p:0]   stg_rdy;
    logic  [stages_p-1:0] in_valid;
    data_t [stages_p-1:0] in_data;
    logic                 accept;
    data_t                a_ext, b_ext, acc_sum, res;

    assign a_ext   = {1'b0, io.a_i};
    assign b_ext   = {1'b0, io.b_i};
    assign acc_sum = acc_q + a_ext;
    assign accept  = io.valid_i & stg_rdy[0];

    // Ready ripples back from the consumer; an empty stage is always ready,
    // which lets bubbles collapse under a stalled output.
    always_comb begin
        stg_rdy           = '0;
        stg_rdy[stages_p] = io.ready_i;
        for (int k = stages_p - 1; k >= 0; k--) begin
            stg_rdy[k] = ~valid_q[k] | stg_rdy[k+1];
        end
    end

    always_comb begin
        res = a_ext + b_ext;
        unique case (io.op_i)
            2'd0: res = a_ext + b_ext;
            2'd1: res = a_ext - b_ext;
            2'd2: res = acc_sum;
            2'd3: res = a_ext;
        endcase
    end

    // Accumulator advances at acceptance so chained ACCs see the fresh value.
    always_comb begin
        acc_d = acc_q;
        if (accept && io.op_i[1]) begin
            acc_d = res;
        end
    end

    // Feed of each stage: input port for stage 0, previous stage otherwise.
    always_comb begin
        in_valid    = '0;
        in_data     = '0;
        in_valid[0] = io.valid_i;
        in_data[0]  = res;
        for (int k = 1; k < stages_p; k++) begin
            in_valid[k] = valid_q[k-1];
            in_data[k]  = data_q[k-1];
        end
    end

    // Data only moves with a valid token, so it holds on bubbles and stalls.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int k = 0; k < stages_p; k++) begin
            if (stg_rdy[k]) begin
                valid_d[k] = in_valid[k];
                if (in_valid[k]) begin
                    data_d[k] = in_data[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_q <= '0;
            data_q  <= '0;
            acc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
        end
    end

    assign io.ready_o = stg_rdy[0];
    assign io.valid_o = valid_q[stages_p-1];
    assign io.c_o     = data_q[stages_p-1];
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed + random checks of addsub_pipe (width 8, 2 stages).
module tb_addsub_pipe;
    logic clk;
    logic rst_n;
    int   ncmp;
    int   nerr;

    addsub_pipe_if #(.width_p(8)) io();

    addsub_pipe #(.width_p(8), .stages_p(2)) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .io       (io)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        io.valid_i = v;
        io.op_i    = op;
        io.a_i     = a;
        io.b_i     = b;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ni, nout, stall, held_v;
        logic        saw_low, have_held, acc_now;
        logic [8:0]  held, e, m_acc;
        logic [8:0]  q[$];

        ncmp = 0;
        nerr = 0;
        rst_n = 1'b0;
        io.ready_i = 1'b0;
        drive(1'b0, 2'd0, 8'd0, 8'd0);

        // Reset state
        #3;
        chk("rst_valid", 32'(io.valid_o), 0);
        chk("rst_c", 32'(io.c_o), 0);
        chk("rst_ready", 32'(io.ready_o), 1);
        #10 rst_n = 1'b1;
        step();

        // Fill both stages, then reset mid-stream
        drive(1'b1, 2'd0, 8'd1, 8'd1);
        step();
        drive(1'b1, 2'd0, 8'd2, 8'd2);
        step();
        chk("full_ready_low", 32'(io.ready_o), 0);
        drive(1'b0, 2'd0, 8'd0, 8'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(io.valid_o), 0);
        chk("midrst_c", 32'(io.c_o), 0);
        chk("midrst_ready", 32'(io.ready_o), 1);
        #2 rst_n = 1'b1;
        io.ready_i = 1'b1;
        drive(1'b1, 2'd2, 8'd5, 8'd0);
        step();
        drive(1'b0, 2'd0, 8'd0, 8'd0);
        chk("acc5_lat", 32'(io.valid_o), 0);
        step();
        chk("acc5_valid", 32'(io.valid_o), 1);
        chk("acc5_c", 32'(io.c_o), 5);
        step();
        chk("acc5_drain", 32'(io.valid_o), 0);

        // ADD/SUB streaming
        drive(1'b1, 2'd0, 8'd255, 8'd255);
        step();
        chk("as_lat", 32'(io.valid_o), 0);
        drive(1'b1, 2'd0, 8'd3, 8'd4);
        step();
        chk("as_v0", 32'(io.valid_o), 1);
        chk("as_c0", 32'(io.c_o), 32'h1FE);
        drive(1'b1, 2'd1, 8'd10, 8'd3);
        step();
        chk("as_c1", 32'(io.c_o), 7);
        drive(1'b1, 2'd1, 8'd3, 8'd10);
        step();
        chk("as_c2", 32'(io.c_o), 7);
        drive(1'b0, 2'd0, 8'd0, 8'd0);
        step();
        chk("as_v3", 32'(io.valid_o), 1);
        chk("as_c3", 32'(io.c_o), 32'h1F9);
        step();
        chk("as_drain", 32'(io.valid_o), 0);

        // Accumulate chain (acc is 5 from the earlier ACC; LOAD overrides it)
        drive(1'b1, 2'd3, 8'd200, 8'd99);
        step();
        drive(1'b1, 2'd2, 8'd100, 8'd99);
        step();
        chk("acc_c0", 32'(io.c_o), 200);
        drive(1'b1, 2'd2, 8'd250, 8'd99);
        step();
        chk("acc_c1", 32'(io.c_o), 300);
        drive(1'b1, 2'd0, 8'd1, 8'd1);
        step();
        chk("acc_c2_wrap", 32'(io.c_o), 38);
        drive(1'b1, 2'd2, 8'd0, 8'd0);
        step();
        chk("acc_c3_add", 32'(io.c_o), 2);
        drive(1'b0, 2'd0, 8'd0, 8'd0);
        step();
        chk("acc_kept", 32'(io.c_o), 38);
        step();

        // Backpressure: 6 ADDs, ready_i low 3 cycles after the 2nd accept
        ni = 0; nout = 0; stall = 0;
        saw_low = 1'b0; have_held = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && nout < 6; cyc++) begin
            drive(ni < 6, 2'd0, 8'(ni + 1), 8'(ni + 1));
            io.ready_i = (stall == 0);
            #1;
            if (!io.ready_o) saw_low = 1'b1;
            if (have_held) begin
                chk("bp_hold_v", 32'(io.valid_o), 1);
                chk("bp_hold_c", 32'(io.c_o), 32'(held));
            end
            have_held = io.valid_o && !io.ready_i;
            held = io.c_o;
            if (io.valid_o && io.ready_i) begin
                chk("bp_out", 32'(io.c_o), 32'(2 * (nout + 1)));
                nout++;
            end
            acc_now = io.valid_i && io.ready_o;
            step();
            if (stall > 0) stall--;
            if (acc_now) begin
                ni++;
                if (ni == 2) stall = 3;
            end
        end
        chk("bp_count", 32'(nout), 6);
        chk("bp_ready_fell", 32'(saw_low), 1);
        drive(1'b0, 2'd0, 8'd0, 8'd0);
        io.ready_i = 1'b1;
        step();
        chk("bp_empty", 32'(io.valid_o), 0);

        // Bubble collapse: stalled output, empty stage 1
        io.ready_i = 1'b0;
        drive(1'b1, 2'd0, 8'd7, 8'd0);
        step();
        drive(1'b0, 2'd0, 8'd0, 8'd0);
        step();
        chk("bub_valid", 32'(io.valid_o), 1);
        chk("bub_ready", 32'(io.ready_o), 1);
        drive(1'b1, 2'd0, 8'd1, 8'd2);
        step();
        drive(1'b0, 2'd0, 8'd0, 8'd0);
        chk("bub_held", 32'(io.c_o), 7);
        chk("bub_full", 32'(io.ready_o), 0);
        io.ready_i = 1'b1;
        step();
        chk("bub_next_v", 32'(io.valid_o), 1);
        chk("bub_next_c", 32'(io.c_o), 3);
        step();
        chk("bub_drain", 32'(io.valid_o), 0);

        // Random valid/ready, all modes, scoreboard from a reset acc
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        m_acc = '0;
        ni = 0;
        held_v = 0;
        for (int cyc = 0; cyc < 60000 && (ni < 10000 || q.size() > 0); cyc++) begin
            drive((ni < 10000) && ($urandom_range(3) != 0), 2'($urandom_range(3)),
                  8'($urandom), 8'($urandom));
            io.ready_i = (ni >= 10000) || ($urandom_range(3) != 0);
            #1;
            chk("rnd_ready", 32'(io.ready_o), 32'(!(q.size() == 2 && !io.ready_i)));
            if (io.valid_o && io.ready_i) begin
                chk("rnd_nodup", 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("rnd_out", 32'(io.c_o), 32'(e));
                    held_v++;
                end
            end
            if (io.valid_i && io.ready_o) begin
                case (io.op_i)
                    2'd0: e = {1'b0, io.a_i} + {1'b0, io.b_i};
                    2'd1: e = {1'b0, io.a_i} - {1'b0, io.b_i};
                    2'd2: begin m_acc = m_acc + {1'b0, io.a_i}; e = m_acc; end
                    default: begin m_acc = {1'b0, io.a_i}; e = m_acc; end
                endcase
                q.push_back(e);
                ni++;
            end
            step();
        end
        chk("rnd_accepted", 32'(ni), 10000);
        chk("rnd_consumed", 32'(held_v), 10000);
        chk("rnd_left", 32'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
